// File: rtl/surf5_spi_flash_seq_if.sv
// Signal bundle between the SURF5 flash command sequencer, its command/read-stream
// clients and the simple SPI core's WISHBONE slave port.
interface surf5_spi_flash_seq_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_opcode_i;
    logic [23:0] cmd_addr_i;
    logic        cmd_addr_en_i;
    logic [1:0]  cmd_dummy_i;
    logic [8:0]  cmd_len_i;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic        done_o;
    logic        err_o;
    logic        cs_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [1:0]  m_adr_o;
    logic [7:0]  m_dat_o;
    logic [7:0]  m_dat_i;
    logic        m_ack_i;

    modport master (
        input  cmd_valid_i, cmd_opcode_i, cmd_addr_i, cmd_addr_en_i, cmd_dummy_i, cmd_len_i,
        input  rd_ready_i, m_dat_i, m_ack_i,
        output cmd_ready_o, rd_data_o, rd_valid_o, done_o, err_o, cs_o,
        output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_opcode_i, cmd_addr_i, cmd_addr_en_i, cmd_dummy_i, cmd_len_i,
        output rd_ready_i, m_dat_i, m_ack_i,
        input  cmd_ready_o, rd_data_o, rd_valid_o, done_o, err_o, cs_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o
    );
endinterface

// File: rtl/surf5_spi_flash_seq.sv
// SURF5 SPI flash command sequencer: expands one flash command into byte transfers on the
// simple SPI core's WISHBONE port, drives the flash select and streams read bytes back.
module surf5_spi_flash_seq #(
    parameter logic [7:0]  SPCR_INIT  = 8'h50,
    parameter int unsigned POLL_LIMIT = 1024,
    parameter int unsigned ACK_LIMIT  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    surf5_spi_flash_seq_if.master io
);

    // state    | meaning
    // IDLE     | accepting a command
    // SPCR     | warm-up: writing the SPI control register
    // CSON     | raising flash select before the opcode
    // WR       | bus write of the tx byte to SPDR
    // POLL     | bus reads of SPSR until the rx FIFO is not empty
    // RDDR     | bus read of SPDR, rx byte captured
    // HOLD     | read byte presented, waiting for rd_ready_i
    // CSOFF    | flash select low, done pulse (normal end or abort)
    typedef enum logic [2:0] {
        ST_IDLE, ST_SPCR, ST_CSON, ST_WR, ST_POLL, ST_RDDR, ST_HOLD, ST_CSOFF
    } state_t;

    typedef enum logic [2:0] {
        STG_WARM, STG_OPC, STG_ADDR, STG_DUMMY, STG_DATA
    } stage_t;

    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
    localparam int unsigned AW = $clog2(ACK_LIMIT + 1);
    localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_LIMIT - 1);
    localparam logic [AW-1:0] ACK_LOAD  = AW'(ACK_LIMIT - 1);
    localparam logic [1:0] A_SPCR = 2'd0;
    localparam logic [1:0] A_SPSR = 2'd1;
    localparam logic [1:0] A_SPDR = 2'd2;

    state_t        state_q, state_d;
    stage_t        stage_q, stage_d;
    logic          gap_q, gap_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [8:0]    rem_q, rem_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [AW-1:0] ack_tmr_q, ack_tmr_d;
    logic          cs_q, cs_d;
    logic          err_q, err_d;
    logic          warm_q, warm_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [7:0]    opc_q, opc_d;
    logic [23:0]   addr_q, addr_d;
    logic          addr_en_q, addr_en_d;
    logic [1:0]    dummy_q, dummy_d;

    logic          bus_st;
    logic          cyc;
    logic          ack;
    logic          ack_to;
    logic          abort;
    logic          advance;
    logic [7:0]    tx_byte;
    logic          m_we;
    logic [1:0]    m_adr;
    logic [7:0]    m_dat;

    // gap_q holds the bus idle for one cycle after every acknowledged access
    assign bus_st = (state_q == ST_SPCR) || (state_q == ST_WR) ||
                    (state_q == ST_POLL) || (state_q == ST_RDDR);
    assign cyc    = bus_st & ~gap_q;
    assign ack    = cyc & io.m_ack_i;
    assign ack_to = cyc & ~io.m_ack_i & (ack_tmr_q == '0);

    always_comb begin
        tx_byte = 8'hFF;
        if (stage_q == STG_OPC) begin
            tx_byte = opc_q;
        end else if (stage_q == STG_ADDR) begin
            case (cnt_q)
                2'd0:    tx_byte = addr_q[23:16];
                2'd1:    tx_byte = addr_q[15:8];
                default: tx_byte = addr_q[7:0];
            endcase
        end
    end

    always_comb begin
        m_we  = 1'b0;
        m_adr = 2'd0;
        m_dat = 8'h00;
        if (cyc) begin
            case (state_q)
                ST_SPCR: begin m_we = 1'b1; m_adr = A_SPCR; m_dat = SPCR_INIT; end
                ST_WR:   begin m_we = 1'b1; m_adr = A_SPDR; m_dat = tx_byte;   end
                ST_POLL: m_adr = A_SPSR;
                ST_RDDR: m_adr = A_SPDR;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        gap_d      = 1'b0;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        poll_d     = poll_q;
        cs_d       = cs_q;
        err_d      = err_q;
        warm_d     = warm_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        opc_d      = opc_q;
        addr_d     = addr_q;
        addr_en_d  = addr_en_q;
        dummy_d    = dummy_q;
        abort      = ack_to;
        advance    = 1'b0;
        ack_tmr_d  = ACK_LOAD;
        if (cyc && !io.m_ack_i) ack_tmr_d = ack_tmr_q - 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (io.cmd_valid_i) begin
                    opc_d     = io.cmd_opcode_i;
                    addr_d    = io.cmd_addr_i;
                    addr_en_d = io.cmd_addr_en_i;
                    dummy_d   = io.cmd_dummy_i;
                    rem_d     = io.cmd_len_i;
                    err_d     = 1'b0;
                    if (!warm_q) begin
                        state_d = ST_SPCR;
                        stage_d = STG_WARM;
                    end else begin
                        state_d = ST_CSON;
                    end
                end
            end
            ST_SPCR: begin
                if (ack) begin
                    state_d = ST_WR;
                    gap_d   = 1'b1;
                end
            end
            ST_CSON: begin
                cs_d    = 1'b1;
                stage_d = STG_OPC;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (ack) begin
                    state_d = ST_POLL;
                    gap_d   = 1'b1;
                    poll_d  = POLL_LOAD;
                end
            end
            ST_POLL: begin
                if (ack) begin
                    gap_d = 1'b1;
                    if (!io.m_dat_i[0]) begin
                        state_d = ST_RDDR;
                    end else if (poll_q == '0) begin
                        abort = 1'b1;
                    end else begin
                        poll_d = poll_q - 1'b1;
                    end
                end
            end
            ST_RDDR: begin
                if (ack) begin
                    case (stage_q)
                        STG_WARM: begin
                            warm_d  = 1'b1;
                            state_d = ST_CSON;
                        end
                        STG_OPC: advance = 1'b1;
                        STG_ADDR: begin
                            if (cnt_q == 2'd2) advance = 1'b1;
                            else begin
                                cnt_d   = cnt_q + 2'd1;
                                state_d = ST_WR;
                                gap_d   = 1'b1;
                            end
                        end
                        STG_DUMMY: begin
                            if (cnt_q == 2'd1) advance = 1'b1;
                            else begin
                                cnt_d   = cnt_q - 2'd1;
                                state_d = ST_WR;
                                gap_d   = 1'b1;
                            end
                        end
                        default: begin
                            state_d    = ST_HOLD;
                            rd_valid_d = 1'b1;
                            rd_data_d  = io.m_dat_i;
                        end
                    endcase
                end
            end
            ST_HOLD: begin
                if (io.rd_ready_i) begin
                    rd_valid_d = 1'b0;
                    rem_d      = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = ST_CSOFF;
                        cs_d    = 1'b0;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_CSOFF: begin
                cs_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // header phase finished: pick the next phase that has work left
        if (advance) begin
            state_d = ST_WR;
            gap_d   = 1'b1;
            if (stage_q == STG_OPC && addr_en_q) begin
                stage_d = STG_ADDR;
                cnt_d   = 2'd0;
            end else if (stage_q != STG_DUMMY && dummy_q != 2'd0) begin
                stage_d = STG_DUMMY;
                cnt_d   = dummy_q;
            end else if (rem_q != 9'd0) begin
                stage_d = STG_DATA;
            end else begin
                state_d = ST_CSOFF;
                cs_d    = 1'b0;
            end
        end

        if (abort) begin
            state_d    = ST_CSOFF;
            cs_d       = 1'b0;
            err_d      = 1'b1;
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            stage_q    <= STG_WARM;
            gap_q      <= 1'b0;
            cnt_q      <= 2'd0;
            rem_q      <= 9'd0;
            poll_q     <= '0;
            ack_tmr_q  <= ACK_LOAD;
            cs_q       <= 1'b0;
            err_q      <= 1'b0;
            warm_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            opc_q      <= 8'h00;
            addr_q     <= 24'h0;
            addr_en_q  <= 1'b0;
            dummy_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            poll_q     <= poll_d;
            ack_tmr_q  <= ack_tmr_d;
            cs_q       <= cs_d;
            err_q      <= err_d;
            warm_q     <= warm_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            opc_q      <= opc_d;
            addr_q     <= addr_d;
            addr_en_q  <= addr_en_d;
            dummy_q    <= dummy_d;
        end
    end

    assign io.cmd_ready_o = (state_q == ST_IDLE);
    assign io.done_o      = (state_q == ST_CSOFF);
    assign io.err_o       = err_q;
    assign io.cs_o        = cs_q;
    assign io.rd_valid_o  = rd_valid_q;
    assign io.rd_data_o   = rd_data_q;
    assign io.m_cyc_o     = cyc;
    assign io.m_stb_o     = cyc;
    assign io.m_we_o      = m_we;
    assign io.m_adr_o     = m_adr;
    assign io.m_dat_o     = m_dat;

endmodule

// File: tb/tb_surf5_spi_flash_seq.sv
// Bench for the SURF5 SPI flash sequencer: SPI core model on the bus, reference byte
// sequences queued per command, independent bus and stream monitors.
module tb_surf5_spi_flash_seq;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    surf5_spi_flash_seq_if ifc ();

    surf5_spi_flash_seq #(
        .SPCR_INIT (8'h50),
        .POLL_LIMIT(1024),
        .ACK_LIMIT (16)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_n),
        .io   (ifc.master)
    );

    int unsigned vec_cnt = 0;
    int unsigned miscmp  = 0;

    logic [8:0] exp_wr[$];
    logic [7:0] rx_plan[$];
    logic [7:0] exp_rd[$];
    logic [7:0] fixed_q[$];
    int         exp_spcr   = 0;
    logic       warm_model = 1'b0;

    logic        rnd_ready   = 1'b0;
    logic        stuck_empty = 1'b0;
    logic        no_ack      = 1'b0;
    int unsigned wait_c = 0, empty_cnt = 0, spsr_reads = 0, wr_cnt = 0;
    int unsigned cyc_run = 0, last_run = 0;
    logic        prev_cyc = 1'b0, prev_ack = 1'b0;
    logic [10:0] prev_sig = '0;
    logic [7:0]  rx_cur = 8'h00;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic cs, input logic [7:0] b);
        exp_wr.push_back({cs, b});
        rx_plan.push_back(8'($urandom));
    endtask

    // Reference: byte sequence on SPDR and bytes expected on the read stream
    task automatic push_cmd(input logic [7:0] opc, input logic [23:0] adr, input logic aen,
                            input logic [1:0] dum, input logic [8:0] len);
        logic [7:0] b;
        if (!warm_model) begin
            exp_spcr++;
            push_wr(1'b0, 8'hFF);
            warm_model = 1'b1;
        end
        push_wr(1'b1, opc);
        if (aen) begin
            push_wr(1'b1, adr[23:16]);
            push_wr(1'b1, adr[15:8]);
            push_wr(1'b1, adr[7:0]);
        end
        for (int i = 0; i < int'(dum); i++) push_wr(1'b1, 8'hFF);
        for (int i = 0; i < int'(len); i++) begin
            if (fixed_q.size() != 0) b = fixed_q.pop_front();
            else b = 8'($urandom);
            exp_wr.push_back({1'b1, 8'hFF});
            rx_plan.push_back(b);
            exp_rd.push_back(b);
        end
    endtask

    task automatic issue(input logic [7:0] opc, input logic [23:0] adr, input logic aen,
                         input logic [1:0] dum, input logic [8:0] len);
        int n;
        n = 0;
        @(negedge clk_i);
        ifc.cmd_opcode_i  = opc;
        ifc.cmd_addr_i    = adr;
        ifc.cmd_addr_en_i = aen;
        ifc.cmd_dummy_i   = dum;
        ifc.cmd_len_i     = len;
        ifc.cmd_valid_i   = 1'b1;
        while (!ifc.cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("cmd_ready", ifc.cmd_ready_o, 1);
        @(negedge clk_i);
        ifc.cmd_valid_i   = 1'b0;
        ifc.cmd_opcode_i  = 8'($urandom);
        ifc.cmd_addr_i    = 24'($urandom);
        ifc.cmd_addr_en_i = 1'($urandom);
        ifc.cmd_dummy_i   = 2'($urandom);
        ifc.cmd_len_i     = 9'($urandom);
        chk("err_clear", ifc.err_o, 0);
        chk("busy_not_ready", ifc.cmd_ready_o, 0);
    endtask

    task automatic wait_done(input logic exp_err, input int limit, input string tag);
        int n;
        n = 0;
        while (!ifc.done_o && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_done"}, ifc.done_o, 1);
        if (ifc.done_o) begin
            chk({tag, "_cs_at_done"}, ifc.cs_o, 0);
            chk({tag, "_err"}, ifc.err_o, 32'(exp_err));
            @(negedge clk_i);
            chk({tag, "_done_pulse"}, ifc.done_o, 0);
            chk({tag, "_ready_after"}, ifc.cmd_ready_o, 1);
            chk({tag, "_err_sticky"}, ifc.err_o, 32'(exp_err));
        end
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        chk({tag, "_spcr_left"}, exp_spcr, 0);
    endtask

    // SPI core model and bus monitor
    always @(negedge clk_i) begin
        logic [8:0] e;
        if (!rst_n) begin
            ifc.m_ack_i = 1'b0;
            ifc.m_dat_i = 8'h00;
            prev_cyc = 1'b0;
            prev_ack = 1'b0;
            cyc_run  = 0;
            wait_c   = 0;
        end else begin
            if (prev_ack) chk("wb_idle_gap", ifc.m_cyc_o, 0);
            if (ifc.m_cyc_o || ifc.m_stb_o) begin
                chk("wb_cyc_stb", ifc.m_stb_o, ifc.m_cyc_o);
                chk("bus_during_rd_valid", ifc.rd_valid_o, 0);
            end
            if (prev_cyc && !prev_ack && ifc.m_cyc_o)
                chk("wb_hold", {ifc.m_adr_o, ifc.m_we_o, ifc.m_dat_o}, prev_sig);
            if (ifc.m_cyc_o) cyc_run++;
            else if (cyc_run != 0) begin
                last_run = cyc_run;
                cyc_run  = 0;
            end
            ifc.m_ack_i = 1'b0;
            if (ifc.m_cyc_o && ifc.m_stb_o && !no_ack) begin
                if (wait_c != 0) wait_c--;
                else begin
                    ifc.m_ack_i = 1'b1;
                    wait_c = $urandom_range(0, 2);
                    if (ifc.m_we_o && ifc.m_adr_o == 2'd0) begin
                        chk("spcr_pending", exp_spcr != 0, 1);
                        if (exp_spcr != 0) begin
                            exp_spcr--;
                            chk("spcr_value", ifc.m_dat_o, 8'h50);
                        end
                    end else if (ifc.m_we_o && ifc.m_adr_o == 2'd2) begin
                        wr_cnt++;
                        spsr_reads = 0;
                        chk("spdr_pending", exp_wr.size() != 0, 1);
                        if (exp_wr.size() != 0) begin
                            e = exp_wr.pop_front();
                            chk("spdr_cs_byte", {ifc.cs_o, ifc.m_dat_o}, e);
                        end
                        rx_cur = (rx_plan.size() != 0) ? rx_plan.pop_front() : 8'($urandom);
                        empty_cnt = $urandom_range(0, 3);
                    end else if (!ifc.m_we_o && ifc.m_adr_o == 2'd1) begin
                        ifc.m_dat_i = {7'h00, stuck_empty || (empty_cnt != 0)};
                        if (empty_cnt != 0) empty_cnt--;
                        spsr_reads++;
                    end else if (!ifc.m_we_o && ifc.m_adr_o == 2'd2) begin
                        ifc.m_dat_i = rx_cur;
                    end
                end
            end
            prev_ack = ifc.m_ack_i;
            prev_cyc = ifc.m_cyc_o;
            prev_sig = {ifc.m_adr_o, ifc.m_we_o, ifc.m_dat_o};
        end
    end

    // Read stream consumer and monitor
    always @(negedge clk_i) begin
        logic [7:0] b;
        if (!rst_n) begin
            ifc.rd_ready_i = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("rd_valid_hold", ifc.rd_valid_o, 1);
                chk("rd_data_hold", ifc.rd_data_o, prev_data);
            end
            ifc.rd_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ifc.rd_valid_o && ifc.rd_ready_i) begin
                chk("rd_pending", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    b = exp_rd.pop_front();
                    chk("rd_data", ifc.rd_data_o, b);
                end
            end
            prev_valid = ifc.rd_valid_o;
            prev_ready = ifc.rd_ready_i;
            prev_data  = ifc.rd_data_o;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r_opc;
        logic [23:0] r_adr;
        logic        r_aen;
        logic [1:0]  r_dum;
        logic [8:0]  r_len;
        int unsigned w0;
        int          n;

        ifc.cmd_valid_i   = 1'b0;
        ifc.cmd_opcode_i  = 8'h00;
        ifc.cmd_addr_i    = 24'h0;
        ifc.cmd_addr_en_i = 1'b0;
        ifc.cmd_dummy_i   = 2'd0;
        ifc.cmd_len_i     = 9'd0;
        ifc.rd_ready_i    = 1'b0;
        ifc.m_ack_i       = 1'b0;
        ifc.m_dat_i       = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", ifc.cmd_ready_o, 1);
        chk("rst_bus", {ifc.m_cyc_o, ifc.m_stb_o, ifc.m_we_o, ifc.m_adr_o, ifc.m_dat_o}, 0);
        chk("rst_misc", {ifc.cs_o, ifc.done_o, ifc.err_o, ifc.rd_valid_o, ifc.rd_data_o}, 0);
        rst_n = 1'b1;
        @(negedge clk_i);

        fixed_q = '{8'hEF, 8'h40, 8'h18};
        push_cmd(8'h9F, 24'h0, 1'b0, 2'd0, 9'd3);
        issue(8'h9F, 24'h0, 1'b0, 2'd0, 9'd3);
        wait_done(1'b0, 2000, "jedec_id");

        push_cmd(8'h03, 24'h123456, 1'b1, 2'd0, 9'd4);
        issue(8'h03, 24'h123456, 1'b1, 2'd0, 9'd4);
        wait_done(1'b0, 2000, "read4");

        push_cmd(8'h06, 24'h0, 1'b0, 2'd0, 9'd0);
        issue(8'h06, 24'h0, 1'b0, 2'd0, 9'd0);
        wait_done(1'b0, 500, "wren");

        rnd_ready = 1'b1;
        r_adr = 24'($urandom);
        push_cmd(8'h0B, r_adr, 1'b1, 2'd1, 9'd256);
        issue(8'h0B, r_adr, 1'b1, 2'd1, 9'd256);
        wait_done(1'b0, 30000, "read256");

        for (int i = 0; i < 8; i++) begin
            r_opc = 8'($urandom);
            r_adr = 24'($urandom);
            r_aen = 1'($urandom);
            r_dum = 2'($urandom);
            r_len = 9'($urandom_range(0, 16));
            push_cmd(r_opc, r_adr, r_aen, r_dum, r_len);
            issue(r_opc, r_adr, r_aen, r_dum, r_len);
            wait_done(1'b0, 3000, "random");
        end
        rnd_ready = 1'b0;

        stuck_empty = 1'b1;
        push_wr(1'b1, 8'h05);
        issue(8'h05, 24'h0, 1'b0, 2'd0, 9'd2);
        wait_done(1'b1, 8000, "poll_abort");
        chk("poll_reads", spsr_reads, 1024);
        stuck_empty = 1'b0;

        no_ack = 1'b1;
        issue(8'h9F, 24'h0, 1'b0, 2'd0, 9'd1);
        wait_done(1'b1, 200, "ack_abort");
        chk("ack_wait_cycles", last_run, 16);
        no_ack = 1'b0;

        w0 = wr_cnt;
        r_adr = 24'($urandom);
        push_cmd(8'h03, r_adr, 1'b1, 2'd2, 9'd5);
        issue(8'h03, r_adr, 1'b1, 2'd2, 9'd5);
        n = 0;
        while (wr_cnt < w0 + 2 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("reached_addr", wr_cnt >= w0 + 2, 1);
        @(negedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", ifc.cmd_ready_o, 1);
        chk("arst_cs", ifc.cs_o, 0);
        chk("arst_bus", {ifc.m_cyc_o, ifc.m_stb_o, ifc.m_we_o, ifc.m_adr_o, ifc.m_dat_o}, 0);
        chk("arst_misc", {ifc.done_o, ifc.err_o, ifc.rd_valid_o, ifc.rd_data_o}, 0);
        exp_wr.delete();
        rx_plan.delete();
        exp_rd.delete();
        exp_spcr   = 0;
        warm_model = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;

        push_cmd(8'h9F, 24'h0, 1'b0, 2'd0, 9'd2);
        issue(8'h9F, 24'h0, 1'b0, 2'd0, 9'd2);
        wait_done(1'b0, 2000, "rewarm");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/surf5_spi_flash_seq.md
Name: surf5_spi_flash_seq

Overview:
- Command sequencer for the SURF5 SPI flash path. It masters the 4-register byte-wide simple SPI core over a private WISHBONE port and drives the flash slave-select.
- Turns one command (opcode, optional 24-bit address, dummy bytes, read length) into the full byte sequence, and returns read bytes on a valid/ready stream.
- Once after reset, it performs the mandatory CCLK warm-up: one dummy byte with slave select deasserted.

Parameters:
- SPCR_INIT, 8'h50, value written to the SPI control register at warm-up (SPE=1, MSTR=1, SPR=00).
- POLL_LIMIT, 1024, maximum status-register reads per byte before abort.
- ACK_LIMIT, 16, maximum cycles a bus cycle may wait for ack before abort.

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, reset, asynchronous, active-low.
- cmd_valid_i, input, 1, command request.
- cmd_ready_o, output, 1, sequencer idle and accepting a command.
- cmd_opcode_i, input, 8, flash opcode.
- cmd_addr_i, input, 24, flash byte address.
- cmd_addr_en_i, input, 1, send 3 address bytes (MSB first).
- cmd_dummy_i, input, 2, number of dummy bytes (0-3), sent as 8'hFF.
- cmd_len_i, input, 9, number of read bytes (0-256).
- rd_data_o, output, 8, read byte.
- rd_valid_o, output, 1, rd_data_o valid.
- rd_ready_i, input, 1, consumer accepts byte.
- done_o, output, 1, one-cycle pulse at command end.
- err_o, output, 1, sticky timeout flag, cleared when the next command is accepted.
- cs_o, output, 1, flash slave select, active high (inverted downstream to CS_B).
- m_cyc_o, output, 1, WISHBONE cycle to the SPI core.
- m_stb_o, output, 1, WISHBONE strobe.
- m_we_o, output, 1, write enable.
- m_adr_o, output, 2, SPI core register index: 0=SPCR, 1=SPSR, 2=SPDR.
- m_dat_o, output, 8, write data.
- m_dat_i, input, 8, read data.
- m_ack_i, input, 1, acknowledge.

Behaviour:
- Reset (rst_i low, async): state IDLE, warm flag cleared.
  - All outputs 0 except cmd_ready_o=1.
  - rd_data_o=8'h00.
  - Reset mid-operation abandons the bus cycle immediately; cs_o drops in the same instant.
- Bus cycle rules:
  - m_cyc_o and m_stb_o rise together and hold with constant adr/we/dat until the first cycle m_ack_i=1.
  - Both deassert the following cycle, with at least one idle cycle between bus cycles.
  - ACK_LIMIT cycles without ack: abort.
- Byte transfer (XFER):
  - Write SPDR with the tx byte.
  - Read SPSR repeatedly until bit0 (RFEMPTY)=0.
  - Read SPDR to capture the rx byte.
  - POLL_LIMIT SPSR reads with RFEMPTY=1: abort.
- Abort: err_o=1, cs_o=0, pulse done_o, return to IDLE. No rd_valid_o for the failed byte.
- States:
  - IDLE: cmd_ready_o=1. cmd_valid_i&cmd_ready_o latches all cmd fields and clears err_o. Go to WARM if warm flag=0, else to CSON.
  - WARM: write SPCR=SPCR_INIT, then XFER 8'hFF with cs_o=0, discard rx, set warm flag. Go to CSON. Runs only once per reset.
  - CSON: cs_o=1 (registered). Then OPC.
  - OPC: XFER opcode, discard rx. Go to ADDR if addr_en, else DUMMY.
  - ADDR: XFER addr[23:16], [15:8], [7:0], discard rx.
  - DUMMY: XFER 8'hFF cmd_dummy times, discard rx. Skipped if 0.
  - DATA: for each of cmd_len bytes, XFER 8'hFF, then present rx on rd_data_o with rd_valid_o=1. Hold until rd_ready_i=1; the next byte's SPDR write starts the cycle after the handshake. A 9-bit remaining counter decrements per accepted byte. Len 0 skips DATA.
  - CSOFF: cs_o=0, pulse done_o, go to IDLE. cmd_ready_o re-asserts the cycle after done_o.
- cmd_valid_i while not IDLE is ignored; cmd_ready_o=0 throughout.
- rd_data_o/rd_valid_o are registered. rd_valid_o never asserts outside DATA.
- No flash-side timing enforced (WIP polling is software's job).

Test Plan:
- Release reset, command opcode 8'h9F, addr_en=0, dummy=0, len=3, with the model returning EF,40,18.
  - Bus shows SPCR write 8'h50.
  - SPDR write FF with cs_o=0.
  - cs_o=1, then SPDR writes 9F,FF,FF,FF.
  - Stream delivers EF,40,18.
  - done_o pulses once.
- Second command 8'h03, addr 24'h123456, len 4.
  - No warm-up.
  - SPDR writes 03,12,34,56,FF×4.
  - 4 bytes streamed.
  - cs_o high exactly from first write to done.
- Command 8'h06, addr_en=0, len=0.
  - Single SPDR write 06, no rd_valid_o, then done_o.
- Read len=256 with rd_ready_i toggled randomly.
  - 256 bytes in order, none dropped or duplicated.
  - No SPDR write while rd_valid_o&!rd_ready_i.
- Model holding RFEMPTY=1 forever: after 1024 SPSR reads, err_o=1, cs_o=0, done_o pulse, cmd_ready_o=1. Separately, m_ack_i stuck low gives the same after 16 cycles.
- Assert rst_i mid-ADDR.
  - Outputs return to reset values asynchronously.
  - The next command repeats the warm-up.
